// File: rtl/ca_seq_pkg.sv
// ---------------------------------------------------------------------------
// ca_seq_pkg
// Shared types and default sizes for the cell-array sequencer.
//   ca_seq_state_t : sequencer FSM state encoding
//   CA_ROWS/CA_COLS: default array geometry (16x16)
//   ca_row_t       : one configuration / result row word
// ---------------------------------------------------------------------------
package ca_seq_pkg;

    localparam int CA_ROWS = 16;
    localparam int CA_COLS = 16;

    typedef logic [CA_COLS-1:0] ca_row_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } ca_seq_state_t;

endpackage

// File: rtl/ca_cfg_regfile.sv
// ---------------------------------------------------------------------------
// ca_cfg_regfile
// ROWS x COLS configuration register bank for the cell array. One row is
// written per cycle when i_we is high; all rows are presented flat on o_cfg.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset, clears every row
//   i_we    : row write enable
//   i_addr  : row index to write
//   i_data  : row word
//   o_cfg   : flat config, row r at bits [r*COLS +: COLS]
// ---------------------------------------------------------------------------
module ca_cfg_regfile #(
    parameter  int ROWS = 16,
    parameter  int COLS = 16,
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [COLS-1:0]      i_data,
    output logic [ROWS*COLS-1:0] o_cfg
);

    logic [ROWS*COLS-1:0] r_cfg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cfg <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (i_we && (i_addr == AW'(r))) begin
                    r_cfg[r*COLS +: COLS] <= i_data;
                end
            end
        end
    end

    assign o_cfg = r_cfg;

endmodule

// File: rtl/ca_array_sequencer.sv
// ---------------------------------------------------------------------------
// ca_array_sequencer
// Loads the cell array configuration row by row from a valid/ready stream,
// enables evaluation for SETTLE_CYCLES cycles, captures one output row and
// returns it on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid/data stable until that edge, and ready
// never depends combinationally on valid.
//
// Optional feature: define SEQ_LOAD_TIMEOUT_EN to abandon LOAD after
// TIMEOUT_CYCLES consecutive cycles without an accepted beat (err pulses).
//
// Ports:
//   FPGA_CLK_50  : clock, rising edge
//   RESET        : asynchronous active-high reset
//   start        : begin a sequence (honoured in IDLE only)
//   abort        : return to IDLE next cycle from any state
//   cfg_data/cfg_valid/cfg_ready : configuration row stream
//   array_cfg    : held configuration, row r at [r*COLS +: COLS]
//   array_en     : array evaluation enable
//   array_out    : array output row
//   result/result_valid/result_ready : captured row stream
//   busy         : high whenever not IDLE
//   err          : one-cycle timeout pulse (0 without the optional feature)
//   dbg_state    : current FSM state
// ---------------------------------------------------------------------------
module ca_array_sequencer
    import ca_seq_pkg::*;
#(
    parameter int ROWS           = CA_ROWS,
    parameter int COLS           = CA_COLS,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 FPGA_CLK_50,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COLS-1:0]      cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [ROWS*COLS-1:0] array_cfg,
    output logic                 array_en,
    input  logic [COLS-1:0]      array_out,
    output logic [COLS-1:0]      result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 err,
    output ca_seq_state_t        dbg_state
);

    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef logic [AW-1:0] row_idx_t;
    typedef logic [SW-1:0] settle_t;
    typedef logic [TW-1:0] stall_t;

    localparam row_idx_t LAST_ROW    = row_idx_t'(ROWS - 1);
    localparam settle_t  LAST_SETTLE = settle_t'(SETTLE_CYCLES - 1);

    ca_seq_state_t   r_state;
    row_idx_t        r_row_cnt;
    settle_t         r_settle_cnt;
    logic            r_cfg_ready;
    logic            r_array_en;
    logic            r_result_valid;
    logic            r_busy;
    logic [COLS-1:0] r_result;
    logic            w_beat;

`ifdef SEQ_LOAD_TIMEOUT_EN
    localparam stall_t LAST_STALL = stall_t'(TIMEOUT_CYCLES - 1);
    stall_t r_stall_cnt;
    logic   r_err;
`endif

    // abort outranks the config handshake, so an aborted beat is not written.
    assign w_beat = (r_state == LOAD) && r_cfg_ready && cfg_valid && !abort;

    ca_cfg_regfile #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cfg_regfile (
        .i_clk  (FPGA_CLK_50),
        .i_rst  (RESET),
        .i_we   (w_beat),
        .i_addr (r_row_cnt),
        .i_data (cfg_data),
        .o_cfg  (array_cfg)
    );

    always_ff @(posedge FPGA_CLK_50 or posedge RESET) begin
        if (RESET) begin
            r_state        <= IDLE;
            r_row_cnt      <= '0;
            r_settle_cnt   <= '0;
            r_cfg_ready    <= 1'b0;
            r_array_en     <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
`ifdef SEQ_LOAD_TIMEOUT_EN
            r_stall_cnt    <= '0;
            r_err          <= 1'b0;
`endif
        end else begin
`ifdef SEQ_LOAD_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            if (abort) begin
                r_state        <= IDLE;
                r_cfg_ready    <= 1'b0;
                r_array_en     <= 1'b0;
                r_result_valid <= 1'b0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state     <= LOAD;
                            r_row_cnt   <= '0;
                            r_cfg_ready <= 1'b1;
                            r_busy      <= 1'b1;
`ifdef SEQ_LOAD_TIMEOUT_EN
                            r_stall_cnt <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        if (w_beat) begin
                            r_row_cnt <= r_row_cnt + 1'b1;
`ifdef SEQ_LOAD_TIMEOUT_EN
                            r_stall_cnt <= '0;
`endif
                            if (r_row_cnt == LAST_ROW) begin
                                r_state      <= SETTLE;
                                r_settle_cnt <= '0;
                                r_cfg_ready  <= 1'b0;
                                r_array_en   <= 1'b1;
                            end
                        end
`ifdef SEQ_LOAD_TIMEOUT_EN
                        else if (r_stall_cnt == LAST_STALL) begin
                            r_err       <= 1'b1;
                            r_state     <= IDLE;
                            r_cfg_ready <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
`endif
                    end
                    SETTLE: begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                        if (r_settle_cnt == LAST_SETTLE) begin
                            r_state    <= CAPTURE;
                            r_array_en <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        r_result       <= array_out;
                        r_result_valid <= 1'b1;
                        r_state        <= DONE;
                    end
                    DONE: begin
                        if (result_ready) begin
                            r_state        <= IDLE;
                            r_result_valid <= 1'b0;
                            r_busy         <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= IDLE;
                        r_cfg_ready    <= 1'b0;
                        r_array_en     <= 1'b0;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign array_en     = r_array_en;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign dbg_state    = r_state;

`ifdef SEQ_LOAD_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
